// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Scans one digit per slot, inserts anode dead-time at every digit switch,
// supports per-digit blank and blink masks, and emits a frame pulse.
// All outputs are registered, so no input reaches a pin combinationally.
module seven_seg_scanner #(
  parameter int SCAN_DIV     = 2500,  // clock cycles per digit slot
  parameter int DEAD_CYCLES  = 2,     // cycles per slot with all anodes off
  parameter int BLINK_FRAMES = 250    // frames per blink half-period
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  blank,
  input  logic [3:0]  blink,
  output logic [3:0]  AN,
  output logic [6:0]  seven_out,
  output logic        frame_tick
);

  // Counter widths follow each counter's terminal count.
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PCNT_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEAD_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // Scan timing state.
  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic [DW-1:0] dead_cnt;

  // Blink timing state.
  logic [BW-1:0] bcnt;
  logic          blink_phase;

  // Slot latch: the digit and its mask bits frozen for the current slot.
  logic          reload;
  logic [3:0]    slot_digit;
  logic          slot_blank;
  logic          slot_blink;

  // Next-cycle output values.
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  // Per-digit view of the packed nibble bus.
  logic [3:0][3:0] digit_arr;
  logic [1:0]      idx_next;
  logic [1:0]      load_sel;
  logic            slot_edge;
  logic            frame_edge;
  logic            slot_off;

  assign digit_arr  = digits;
  assign idx_next   = idx + 2'd1;
  assign slot_edge  = (pcnt == PCNT_LAST);
  assign frame_edge = slot_edge && (idx == 2'd3);
  // Right after reset the latch is filled with the current digit 0;
  // at every slot edge it is filled with the digit about to be shown.
  assign load_sel   = reload ? idx : idx_next;

  // Hex to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Prescaler, digit index and dead-time counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pcnt     <= '0;
      idx      <= 2'd0;
      dead_cnt <= DEAD_LOAD;
    end else begin
      if (slot_edge) begin
        pcnt     <= '0;
        idx      <= idx_next;
        dead_cnt <= DEAD_LOAD;
      end else begin
        pcnt <= pcnt + 1'b1;
        if (dead_cnt != '0) begin
          dead_cnt <= dead_cnt - 1'b1;
        end
      end
    end
  end

  // Slot latch: mid-slot input changes wait for the next visit to that digit.
  // NOTE: the latch resets to "blanked" so nothing stale can light up in the
  // one cycle before the first post-reset load.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      reload     <= 1'b1;
      slot_digit <= 4'h0;
      slot_blank <= 1'b1;
      slot_blink <= 1'b0;
    end else begin
      reload <= 1'b0;
      if (reload || slot_edge) begin
        slot_digit <= digit_arr[load_sel];
        slot_blank <= blank[load_sel];
        slot_blink <= blink[load_sel];
      end
    end
  end

  // Blink counter: counts completed frames and toggles the phase on wrap.
  // It advances on the same edge that raises frame_tick, so the new phase
  // is already in force for the first cycle of the next frame.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      bcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (frame_edge) begin
      if (bcnt == BLINK_LAST) begin
        bcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Next output values: segments follow the latch for the whole slot,
  // the anode only after the dead period has expired.
  // NOTE: outputs get their dark defaults first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    an_next  = 4'hF;
    seg_next = 7'h7F;
    slot_off = slot_blank || (slot_blink && blink_phase);
    if (en && !slot_off) begin
      seg_next = hex_to_seg(slot_digit);
      if (dead_cnt == '0) begin
        an_next = ~(4'b0001 << idx);
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      AN         <= 4'hF;
      seven_out  <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      AN         <= an_next;
      seven_out  <= seg_next;
      frame_tick <= frame_edge;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with SCAN_DIV=8, DEAD_CYCLES=2,
// BLINK_FRAMES=2. Expected outputs are derived from the cycle count since
// reset release and pushed to a scoreboard queue as each cycle is driven.
module tb_seven_seg_scanner;

  localparam int SD = 8;
  localparam int DC = 2;
  localparam int BF = 2;

  logic        clk_in = 1'b0;
  logic        rst    = 1'b1;
  logic        en     = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  blank  = 4'b0000;
  logic [3:0]  blink  = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seven_out;
  logic        frame_tick;

  seven_seg_scanner #(
    .SCAN_DIV    (SD),
    .DEAD_CYCLES (DC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .digits    (digits),
    .blank     (blank),
    .blink     (blink),
    .AN        (an),
    .seven_out (seven_out),
    .frame_tick(frame_tick)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       ft;
  } exp_t;

  typedef struct packed {
    logic            rst;
    logic [15:0]     digits;
    logic [3:0]      blank;
    logic [3:0]      blink;
    logic [3:0][6:0] seg;     // expected decode of each digit, {d3,d2,d1,d0}
    logic [15:0]     cycles;
  } vec_t;

  // Hand-decoded segment patterns {d3,d2,d1,d0}.
  localparam logic [3:0][6:0] S1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [3:0][6:0] SFA80 = {7'h0E, 7'h08, 7'h00, 7'h40};
  localparam logic [3:0][6:0] SBDE9 = {7'h03, 7'h21, 7'h06, 7'h10};
  localparam logic [3:0][6:0] S67C5 = {7'h02, 7'h78, 7'h46, 7'h12};
  localparam logic [3:0][6:0] S0001 = {7'h40, 7'h40, 7'h40, 7'h79};
  localparam logic [3:0][6:0] S0007 = {7'h40, 7'h40, 7'h40, 7'h78};

  int              t;          // edges since reset release
  int              n_pass;
  int              n_chk;
  logic [3:0][6:0] cur_seg;    // expected decode of what is on digits now
  logic [3:0][6:0] snap_seg;   // what the display is committed to show
  logic [3:0]      snap_blank;
  logic [3:0]      snap_blink;
  exp_t            sb_q[$];
  vec_t            tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
  endtask

  // Drive one cycle: predict the post-edge outputs, queue them, then compare.
  task automatic step();
    exp_t e;
    int   s;
    int   pos;
    int   ph;
    logic off;
    if (rst) begin
      e = '{an: 4'hF, seg: 7'h7F, ft: 1'b0};
      t = 0;
    end else begin
      t++;
      s     = ((t - 1) / SD) % 4;
      pos   = (t - 1) % SD;
      ph    = ((t - 1) / (BF * 4 * SD)) % 2;
      off   = snap_blank[s] | (snap_blink[s] & (ph == 1));
      e.an  = (!en || off || pos < DC) ? 4'hF : ~(4'b0001 << s);
      e.seg = (!en || off || t == 1) ? 7'h7F : snap_seg[s];
      e.ft  = (t % (4 * SD) == 0);
      if (t == 1 || t % SD == 0) begin
        snap_seg   = cur_seg;
        snap_blank = blank;
        snap_blink = blink;
      end
    end
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("AN", 32'(an), 32'(e.an));
      check("seven_out", 32'(seven_out), 32'(e.seg));
      check("frame_tick", 32'(frame_tick), 32'(e.ft));
      check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    end
  endtask

  function automatic vec_t mkv(input logic r, input logic [15:0] d, input logic [3:0] bl,
                               input logic [3:0] bk, input logic [3:0][6:0] sg, input int n);
    vec_t v;
    v.rst    = r;
    v.digits = d;
    v.blank  = bl;
    v.blink  = bk;
    v.seg    = sg;
    v.cycles = 16'(n);
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int gap;
    t          = 0;
    n_pass     = 0;
    n_chk      = 0;
    cur_seg    = S1234;
    snap_seg   = '1;
    snap_blank = 4'b0000;
    snap_blink = 4'b0000;

    tbl[0] = mkv(1'b1, 16'h1234, 4'b0000, 4'b0000, S1234, 3);
    tbl[1] = mkv(1'b0, 16'h1234, 4'b0000, 4'b0000, S1234, 96);
    tbl[2] = mkv(1'b0, 16'hFA80, 4'b0000, 4'b0000, SFA80, 64);
    tbl[3] = mkv(1'b0, 16'hBDE9, 4'b0000, 4'b0000, SBDE9, 64);
    tbl[4] = mkv(1'b0, 16'h67C5, 4'b0000, 4'b0000, S67C5, 64);
    tbl[5] = mkv(1'b0, 16'h1234, 4'b0100, 4'b0000, S1234, 64);
    tbl[6] = mkv(1'b1, 16'h1234, 4'b0000, 4'b0001, S1234, 1);
    tbl[7] = mkv(1'b0, 16'h1234, 4'b0000, 4'b0001, S1234, 160);

    for (int i = 0; i < 8; i++) begin
      rst     = tbl[i].rst;
      digits  = tbl[i].digits;
      blank   = tbl[i].blank;
      blink   = tbl[i].blink;
      cur_seg = tbl[i].seg;
      for (int c = 0; c < int'(tbl[i].cycles); c++) step();
    end

    // Mid-slot digit change: current slot keeps "1", next visit shows "7".
    blank   = 4'b0000;
    blink   = 4'b0000;
    rst     = 1'b1;
    digits  = 16'h0001;
    cur_seg = S0001;
    step();
    rst = 1'b0;
    repeat (5) step();
    digits  = 16'h0007;
    cur_seg = S0007;
    step();
    check("midslot_hold_seg", 32'(seven_out), 32'h79);
    check("midslot_hold_an", 32'(an), 32'hE);
    while (t < 33) step();
    check("next_visit_seg", 32'(seven_out), 32'h78);
    while (t < 35) step();
    check("next_visit_an", 32'(an), 32'hE);

    // Reset during slot 2, then measure the latency to the first lit anode.
    digits  = 16'h1234;
    cur_seg = S1234;
    for (int k = 0; k < 64 && (t % 32) != 19; k++) step();
    rst = 1'b1;
    step();
    check("rst_dark_an", 32'(an), 32'hF);
    check("rst_dark_seg", 32'(seven_out), 32'h7F);
    rst = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (an == 4'hF && lat < 10);
    check("rst_latency", 32'(lat), 32'd3);
    check("rst_first_an", 32'(an), 32'hE);

    // Frame pulse period.
    for (int k = 0; k < 40 && !frame_tick; k++) step();
    gap = 0;
    do begin
      step();
      gap++;
    end while (!frame_tick && gap < 40);
    check("frame_period", 32'(gap), 32'd32);

    // Display disable for 10 cycles, then phase-coherent resume.
    en = 1'b0;
    repeat (10) step();
    check("disabled_an", 32'(an), 32'hF);
    check("disabled_seg", 32'(seven_out), 32'h7F);
    en = 1'b1;
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
